csi_packet_sequencer: RTL and testbench
=======================================

Name: csi_packet_sequencer

Overview:
- Sequences CSI-2 packet reception after the lane/byte-alignment and header-ECC stages, all in the mipi_clk domain.
- Classifies each ECC-checked header as short or long and tracks frame/line state.
- Counts long-packet payload words and writes RAW8 pixel words into a line-strided frame buffer.
- Drives recieve_data back to the SoT FSM so it holds HS reception open for the packet.

Parameters:
- VC_SEL, 0, only packets on this virtual channel are processed; others are ignored.
- LINE_STRIDE, 160, buffer words per line (640 RAW8 pixels).
- MAX_LINES, 480, lines stored per frame; later lines are skipped.
- ADDR_W, 18, write address width.

Ports:
- mipi_clk  in  1  sole clock
- reset  in  1  asynchronous, active-low
- stop  in  1  high = lanes in LP/stop; aborts any packet
- header_valid  in  1  one-cycle pulse, header passed ECC
- header  in  32  [5:0] DT, [7:6] VC, [23:8] WC in bytes, [31:24] ECC
- data_valid  in  1  one payload word present
- data_in  in  32  payload bytes, byte0 in [7:0]
- recieve_data  out  1  high while a long packet is being consumed
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  line*LINE_STRIDE + word index
- wr_data  out  32  registered data_in
- wr_be  out  4  byte enables, bit i = byte i
- frame_start, frame_end, line_start, line_end  out  1 each  one-cycle pulses
- frame_active  out  1  between FS and FE
- frame_count  out  16  completed frames, wraps at 0xFFFF->0
- line_count  out  16  lines stored in current frame
- err_flags  out  3  sticky: [0] truncated, [1] overflow, [2] long packet outside frame; cleared on FS

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - All outputs 0; frame_count, line_count, err_flags = 0.
  - Word counters = 0.
- States: IDLE, PAYLOAD (consume and write), SKIP (consume, no write).
- IDLE, on header_valid with VC==VC_SEL and stop==0:
  - DT 0x00 (FS): frame_start pulse next cycle; frame_active<=1; line_count<=0; err_flags<=0.
  - DT 0x01 (FE): frame_end pulse; frame_active<=0; frame_count+1. FE while not frame_active: pulse only, no increment.
  - DT 0x02-0x0F (short): ignored; stay IDLE.
  - DT>=0x10 (long):
    - N = (WC+5)>>2 total words, including the 2 CRC bytes.
    - W = (WC+3)>>2 data words.
    - k counter <= 0; recieve_data<=1 next cycle.
    - Goes to PAYLOAD only if DT==0x2A, frame_active, line_count<MAX_LINES and W<=LINE_STRIDE. line_start pulses in the same cycle.
    - Otherwise goes to SKIP, setting err[2] if not frame_active and err[1] if the line count or W limit failed. Other DTs skip with no error.
- header_valid with a VC mismatch, or while not in IDLE: ignored.
- PAYLOAD/SKIP word handling:
  - Each data_valid consumes one word; k increments.
  - In PAYLOAD with k<W, the cycle after data_valid: wr_en=1, wr_data=data_in, wr_addr=line_count*LINE_STRIDE+k.
  - wr_be=4'hF, except for the last data word: 4'b0001/0011/0111 for WC%4 = 1/2/3.
  - Words with k>=W (CRC) are consumed without a write.
- Completion: on the word where k==N-1:
  - Next cycle: IDLE, recieve_data<=0.
  - If in PAYLOAD: line_end pulse and line_count+1 in that cycle.
- WC=0: N=1, W=0; one word consumed, no writes; line_end still pulses if in PAYLOAD.
- stop=1 in PAYLOAD/SKIP:
  - Next cycle: IDLE, recieve_data=0, err[0] set.
  - No line_end; line_count unchanged; any pending write from the previous cycle still completes.
- stop=1 in IDLE: header_valid ignored.
- stop coincident with header_valid: stop wins.
- data_valid in IDLE: ignored.
- Latency:
  - header_valid to pulses/recieve_data: 1 cycle.
  - data_valid to wr_en: 1 cycle.
  - Back-to-back data_valid gives back-to-back writes.
- Arithmetic:
  - Address product truncated to ADDR_W bits.
  - N/W computed in 17 bits; WC=0xFFFF does not overflow.

Test Plan:
- Reset with reset=0 mid-PAYLOAD -> next cycle all outputs 0, state IDLE; releasing reset with no stimulus keeps wr_en=0.
- FS (VC0), RAW8 WC=640 with 161 data_valid, then FE:
  - 160 writes at addr 0..159, all wr_be=F; the 161st (CRC) word is not written.
  - One line_start, one line_end; line_count=1; frame_count=1.
- RAW8 WC=6 as line 2 (line_count=2):
  - N=2, W=2; writes at 320 (be=F) and 321 (be=0011).
  - recieve_data low 1 cycle after the 2nd word.
- stop asserted after 3 of 161 words -> 3 writes, err_flags=001, no line_end, line_count unchanged, recieve_data=0 next cycle.
- Overflow/out-of-frame:
  - RAW8 WC=644 (W=161) -> SKIP, no writes, err[1].
  - RAW8 before any FS -> SKIP, err[2].
  - A following FS clears err_flags to 000.
- VC=1 header, and header_valid arriving during PAYLOAD -> both ignored; no pulses, no counter change.

Source files
------------

// File: rtl/csi_packet_sequencer.sv
// rtl/csi_packet_sequencer.sv - CSI-2 packet sequencer: header classification, frame/line tracking, RAW8 line-strided buffer writes
module csi_packet_sequencer #(
    parameter int VC_SEL      = 0,
    parameter int LINE_STRIDE = 160,
    parameter int MAX_LINES   = 480,
    parameter int ADDR_W      = 18
) (
    input  logic              mipi_clk,
    input  logic              reset,
    input  logic              stop,
    input  logic              header_valid,
    input  logic [31:0]       header,
    input  logic              data_valid,
    input  logic [31:0]       data_in,
    output logic              recieve_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    output logic              frame_start,
    output logic              frame_end,
    output logic              line_start,
    output logic              line_end,
    output logic              frame_active,
    output logic [15:0]       frame_count,
    output logic [15:0]       line_count,
    output logic [2:0]        err_flags
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        SKIP    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [16:0]       k;
    logic [16:0]       n_words;
    logic [16:0]       w_words;
    logic [1:0]        wc_low;

    logic [5:0]        dt;
    logic [15:0]       wc;
    logic [16:0]       n_calc;
    logic [16:0]       w_calc;
    logic              hdr_ok;
    logic              is_long;
    logic              is_raw8;
    logic              limits_ok;
    logic              go_payload;
    logic              consume;
    logic              last_word;
    logic [3:0]        be_last;
    logic [ADDR_W-1:0] addr_calc;
    logic              unused_ecc;

    assign dt         = header[5:0];
    assign wc         = header[23:8];
    assign unused_ecc = ^header[31:24];

    // 17-bit arithmetic so WC=0xFFFF cannot wrap
    assign n_calc     = ({1'b0, wc} + 17'd5) >> 2;
    assign w_calc     = ({1'b0, wc} + 17'd3) >> 2;

    assign hdr_ok     = header_valid && !stop && (state == IDLE) && (header[7:6] == 2'(VC_SEL));
    assign is_long    = (dt >= 6'h10);
    assign is_raw8    = (dt == 6'h2A);
    assign limits_ok  = (line_count < 16'(MAX_LINES)) && (w_calc <= 17'(LINE_STRIDE));
    assign go_payload = is_raw8 && frame_active && limits_ok;

    // stop aborts the packet, so a word presented alongside it is dropped
    assign consume    = data_valid && (state != IDLE) && !stop;
    assign last_word  = consume && (k == n_words - 17'd1);

    assign addr_calc  = ADDR_W'(32'(line_count) * 32'(LINE_STRIDE) + 32'(k));
    assign recieve_data = (state != IDLE);

    always_comb begin
        be_last = 4'hF;
        case (wc_low)
            2'd1:    be_last = 4'b0001;
            2'd2:    be_last = 4'b0011;
            2'd3:    be_last = 4'b0111;
            default: be_last = 4'hF;
        endcase
    end

    always_ff @(posedge mipi_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hdr_ok && is_long) begin
                    state_next = go_payload ? PAYLOAD : SKIP;
                end
            end
            PAYLOAD, SKIP: begin
                if (stop || last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mipi_clk or negedge reset) begin
        if (!reset) begin
            k            <= '0;
            n_words      <= '0;
            w_words      <= '0;
            wc_low       <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_be        <= '0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            line_start   <= 1'b0;
            line_end     <= 1'b0;
            frame_active <= 1'b0;
            frame_count  <= '0;
            line_count   <= '0;
            err_flags    <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            wr_en       <= 1'b0;

            if (hdr_ok) begin
                if (dt == 6'h00) begin
                    frame_start  <= 1'b1;
                    frame_active <= 1'b1;
                    line_count   <= '0;
                    err_flags    <= '0;
                end else if (dt == 6'h01) begin
                    frame_end    <= 1'b1;
                    frame_active <= 1'b0;
                    if (frame_active) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end else if (is_long) begin
                    k       <= '0;
                    n_words <= n_calc;
                    w_words <= w_calc;
                    wc_low  <= wc[1:0];
                    if (go_payload) begin
                        line_start <= 1'b1;
                    end else if (is_raw8) begin
                        if (!frame_active) begin
                            err_flags[2] <= 1'b1;
                        end else begin
                            err_flags[1] <= 1'b1;
                        end
                    end
                end
            end

            if ((state != IDLE) && stop) begin
                err_flags[0] <= 1'b1;
            end

            if (consume) begin
                k <= k + 17'd1;
                if ((state == PAYLOAD) && (k < w_words)) begin
                    wr_en   <= 1'b1;
                    wr_data <= data_in;
                    wr_addr <= addr_calc;
                    wr_be   <= (k == w_words - 17'd1) ? be_last : 4'hF;
                end
                if (last_word && (state == PAYLOAD)) begin
                    line_end   <= 1'b1;
                    line_count <= line_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// tb/tb_csi_packet_sequencer.sv - scoreboard bench for csi_packet_sequencer
module tb_csi_packet_sequencer;

    logic        mipi_clk = 1'b0;
    logic        reset    = 1'b0;
    logic        stop     = 1'b0;
    logic        header_valid = 1'b0;
    logic [31:0] header   = '0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in  = '0;
    logic        recieve_data;
    logic        wr_en;
    logic [17:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        frame_start, frame_end, line_start, line_end;
    logic        frame_active;
    logic [15:0] frame_count, line_count;
    logic [2:0]  err_flags;

    csi_packet_sequencer dut (
        .mipi_clk     (mipi_clk),
        .reset        (reset),
        .stop         (stop),
        .header_valid (header_valid),
        .header       (header),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .recieve_data (recieve_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .line_start   (line_start),
        .line_end     (line_end),
        .frame_active (frame_active),
        .frame_count  (frame_count),
        .line_count   (line_count),
        .err_flags    (err_flags)
    );

    always #5 mipi_clk = ~mipi_clk;

    typedef struct {
        logic [17:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  n_fs = 0, n_fe = 0, n_ls = 0, n_le = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write and tallies pulses
    always @(negedge mipi_clk) begin
        if (reset) begin
            if (frame_start) n_fs++;
            if (frame_end)   n_fe++;
            if (line_start)  n_ls++;
            if (line_end)    n_le++;
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h be %0h", wr_addr, wr_data, wr_be);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data || wr_be !== e.be) begin
                        errors++;
                        $display("FAIL write: got addr %0d data %0h be %0h expected addr %0d data %0h be %0h",
                                 wr_addr, wr_data, wr_be, e.addr, e.data, e.be);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge mipi_clk);
        #1;
    endtask

    task automatic hdr(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc);
        header_valid = 1'b1;
        header       = {8'h00, wc, vc, dt};
        tick();
        header_valid = 1'b0;
    endtask

    task automatic word(input logic [31:0] d, input logic exp_wr, input logic [17:0] addr, input logic [3:0] be);
        wr_t e;
        if (exp_wr) begin
            e.addr = addr;
            e.data = d;
            e.be   = be;
            exp_q.push_back(e);
        end
        data_valid = 1'b1;
        data_in    = d;
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_rx", 32'(recieve_data), 0);
        chk("reset_frame_count", 32'(frame_count), 0);
        chk("reset_line_count", 32'(line_count), 0);
        chk("reset_err", 32'(err_flags), 0);
        chk("reset_frame_active", 32'(frame_active), 0);
        reset = 1'b1;
        tick();

        // RAW8 before any FS
        hdr(6'h2A, 2'd0, 16'd6);
        chk("oof_err", 32'(err_flags), 32'b100);
        chk("oof_rx", 32'(recieve_data), 1);
        chk("oof_ls", 32'(line_start), 0);
        word(32'h11111111, 1'b0, 0, 0);
        word(32'h22222222, 1'b0, 0, 0);
        chk("oof_rx_done", 32'(recieve_data), 0);

        hdr(6'h00, 2'd0, 16'd0);
        chk("fs_pulse", 32'(frame_start), 1);
        chk("fs_err_clr", 32'(err_flags), 0);
        chk("fs_active", 32'(frame_active), 1);

        // Line 0: WC=640, 160 data words + CRC word
        hdr(6'h2A, 2'd0, 16'd640);
        chk("l0_ls", 32'(line_start), 1);
        chk("l0_rx", 32'(recieve_data), 1);
        for (int i = 0; i < 161; i++) begin
            word(32'hA0000000 + 32'(i), i < 160, 18'(i), 4'hF);
        end
        chk("l0_rx_done", 32'(recieve_data), 0);
        chk("l0_le", 32'(line_end), 1);
        chk("l0_lc", 32'(line_count), 1);

        // Line 1: WC=8 -> N=3, W=2
        hdr(6'h2A, 2'd0, 16'd8);
        word(32'hB0000000, 1'b1, 18'd160, 4'hF);
        word(32'hB0000001, 1'b1, 18'd161, 4'hF);
        word(32'hB0000002, 1'b0, 0, 0);
        chk("l1_lc", 32'(line_count), 2);

        // Line 2: WC=6 -> N=2, W=2, last be=0011
        hdr(6'h2A, 2'd0, 16'd6);
        word(32'hC0000000, 1'b1, 18'd320, 4'hF);
        chk("l2_rx_mid", 32'(recieve_data), 1);
        word(32'hC0000001, 1'b1, 18'd321, 4'b0011);
        chk("l2_rx_done", 32'(recieve_data), 0);
        chk("l2_lc", 32'(line_count), 3);

        // Other-VC headers are ignored
        hdr(6'h2A, 2'd1, 16'd6);
        chk("vc1_rx", 32'(recieve_data), 0);
        chk("vc1_ls", 32'(line_start), 0);
        hdr(6'h00, 2'd1, 16'd0);
        chk("vc1_fs", 32'(frame_start), 0);

        // Line 3: WC=12 -> N=4, W=3, with an FS header mid-payload
        hdr(6'h2A, 2'd0, 16'd12);
        word(32'hD0000000, 1'b1, 18'd480, 4'hF);
        hdr(6'h00, 2'd0, 16'd0);
        chk("midpkt_fs", 32'(frame_start), 0);
        chk("midpkt_lc", 32'(line_count), 3);
        word(32'hD0000001, 1'b1, 18'd481, 4'hF);
        word(32'hD0000002, 1'b1, 18'd482, 4'hF);
        word(32'hD0000003, 1'b0, 0, 0);
        chk("l3_lc", 32'(line_count), 4);

        // Line 4 aborted by stop after 3 words
        hdr(6'h2A, 2'd0, 16'd640);
        for (int i = 0; i < 3; i++) begin
            word(32'hE0000000 + 32'(i), 1'b1, 18'd640 + 18'(i), 4'hF);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_rx", 32'(recieve_data), 0);
        chk("stop_err", 32'(err_flags), 32'b001);
        chk("stop_lc", 32'(line_count), 4);
        chk("stop_le", 32'(line_end), 0);

        // Overflow: WC=644 -> W=161 > stride, N=162 words skipped
        hdr(6'h2A, 2'd0, 16'd644);
        chk("ovf_err", 32'(err_flags), 32'b011);
        chk("ovf_rx", 32'(recieve_data), 1);
        chk("ovf_ls", 32'(line_start), 0);
        for (int i = 0; i < 162; i++) begin
            word(32'hF0000000 + 32'(i), 1'b0, 0, 0);
        end
        chk("ovf_rx_done", 32'(recieve_data), 0);
        chk("ovf_lc", 32'(line_count), 4);

        // WC=0: one word, no writes, line still ends
        hdr(6'h2A, 2'd0, 16'd0);
        word(32'h12345678, 1'b0, 0, 0);
        chk("wc0_le", 32'(line_end), 1);
        chk("wc0_lc", 32'(line_count), 5);

        hdr(6'h01, 2'd0, 16'd0);
        chk("fe_pulse", 32'(frame_end), 1);
        chk("fe_count", 32'(frame_count), 1);
        chk("fe_active", 32'(frame_active), 0);
        hdr(6'h01, 2'd0, 16'd0);
        chk("fe2_pulse", 32'(frame_end), 1);
        chk("fe2_count", 32'(frame_count), 1);

        hdr(6'h00, 2'd0, 16'd0);
        chk("fs2_err_clr", 32'(err_flags), 0);
        chk("fs2_lc", 32'(line_count), 0);

        // Reset asserted mid-payload
        hdr(6'h2A, 2'd0, 16'd640);
        word(32'h55550000, 1'b1, 18'd0, 4'hF);
        word(32'h55550001, 1'b1, 18'd1, 4'hF);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rx", 32'(recieve_data), 0);
        chk("rst_fc", 32'(frame_count), 0);
        chk("rst_lc", 32'(line_count), 0);
        chk("rst_active", 32'(frame_active), 0);
        chk("rst_addr", 32'(wr_addr), 0);
        reset = 1'b1;
        repeat (4) tick();
        chk("post_rst_wr_en", 32'(wr_en), 0);
        chk("post_rst_rx", 32'(recieve_data), 0);

        chk("count_fs", 32'(n_fs), 2);
        chk("count_fe", 32'(n_fe), 2);
        chk("count_ls", 32'(n_ls), 7);
        chk("count_le", 32'(n_le), 5);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
